// File: rtl/fp_adder_arb_pkg.sv
// Shared types for the FP adder arbiter.
// FSM state encoding and float width.
package fp_adder_arb_pkg;

    localparam int FP_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_Z,
        RESP
    } state_e;

endpackage

// File: rtl/fp_adder_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first asserted request at or after ptr_i.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic             valid_o,
    output logic [IDW-1:0]   idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr_i) + k) % N_REQ;
            if (req_i[j]) begin
                valid_o = 1'b1;
                idx_o   = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter sharing one stb/ack FP adder among N_REQ clients.
// Define ADDER_ARB_PERF_EN to add per-requester completion counters.
module fp_adder_arbiter
    import fp_adder_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int IDW    = 2,
    parameter int PERF_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*FP_W-1:0] req_a,
    input  logic [N_REQ*FP_W-1:0] req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]       rsp_z,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [FP_W-1:0]       add_a,
    output logic [FP_W-1:0]       add_b,
    output logic                  add_a_stb,
    output logic                  add_b_stb,
    input  logic                  add_a_ack,
    input  logic                  add_b_ack,
    input  logic [FP_W-1:0]       add_z,
    input  logic                  add_z_stb,
    output logic                  add_z_ack,
`ifdef ADDER_ARB_PERF_EN
    output logic [N_REQ*PERF_W-1:0] perf_cnt,
`endif
    output logic                  busy,
    output logic [IDW-1:0]        grant_id
);

    state_e            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [FP_W-1:0]   a_q, a_d;
    logic [FP_W-1:0]   b_q, b_d;
    logic [FP_W-1:0]   z_q, z_d;
    logic              pick_v;
    logic [IDW-1:0]    pick_idx;
    logic              rsp_done;
    logic [N_REQ-1:0]  one;

    assign one = N_REQ'(1);

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_v),
        .idx_o   (pick_idx)
    );

    assign rsp_done = (state_q == RESP) && rsp_ready[grant_q];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        a_d      = a_q;
        b_d      = b_q;
        z_d      = z_q;
        unique case (state_q)
            IDLE: begin
                if (pick_v) begin
                    a_d      = req_a[FP_W*pick_idx +: FP_W];
                    b_d      = req_b[FP_W*pick_idx +: FP_W];
                    grant_d  = pick_idx;
                    rr_ptr_d = (pick_idx == IDW'(N_REQ - 1)) ? '0
                                                              : pick_idx + 1'b1;
                    state_d  = SEND_A;
                end
            end
            SEND_A: if (add_a_ack) state_d = SEND_B;
            SEND_B: if (add_b_ack) state_d = WAIT_Z;
            WAIT_Z: begin
                if (add_z_stb) begin
                    z_d     = add_z;
                    state_d = RESP;
                end
            end
            RESP: if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            z_q      <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            a_q      <= a_d;
            b_q      <= b_d;
            z_q      <= z_d;
        end
    end

    // Reset forces IDLE, so the accept strobe is masked while it is held.
    assign req_ready = (!reset && state_q == IDLE && pick_v) ? (one << pick_idx)
                                                             : '0;
    assign rsp_valid = (state_q == RESP) ? (one << grant_q) : '0;
    assign rsp_z     = z_q;
    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_a_stb = (state_q == SEND_A);
    assign add_b_stb = (state_q == SEND_B);
    assign add_z_ack = (state_q == WAIT_Z);
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;

`ifdef ADDER_ARB_PERF_EN
    logic [N_REQ-1:0][PERF_W-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (rsp_done) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
        end
    end

    assign perf_cnt = cnt_q;
`endif

endmodule
